// File: rtl/fpu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq_ctrl_if
// Brief    : Core-side request/response and ALU-side signals of the FP sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_seq_ctrl_if;
    logic        istart;
    logic [3:0]  iop;
    logic [31:0] idataa;
    logic [31:0] idatab;
    logic        oready;
    logic        obusy;
    logic        odone;
    logic [3:0]  oalu_control;
    logic [31:0] oalu_dataa;
    logic [31:0] oalu_datab;
    logic [31:0] ialu_result;
    logic        ialu_nan;
    logic        ialu_zero;
    logic        ialu_overflow;
    logic        ialu_underflow;
    logic        ialu_comp;
    logic [31:0] oresult;
    logic        onan;
    logic        ozero;
    logic        ooverflow;
    logic        ounderflow;
    logic        oCompResult;

    modport slave (
        input  istart, iop, idataa, idatab,
        input  ialu_result, ialu_nan, ialu_zero, ialu_overflow, ialu_underflow, ialu_comp,
        output oready, obusy, odone,
        output oalu_control, oalu_dataa, oalu_datab,
        output oresult, onan, ozero, ooverflow, ounderflow, oCompResult
    );

    modport master (
        output istart, iop, idataa, idatab,
        output ialu_result, ialu_nan, ialu_zero, ialu_overflow, ialu_underflow, ialu_comp,
        input  oready, obusy, odone,
        input  oalu_control, oalu_dataa, oalu_datab,
        input  oresult, onan, ozero, ooverflow, ounderflow, oCompResult
    );
endinterface
`default_nettype wire

// File: rtl/fpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq_ctrl
// Brief    : Sequences one FP op at a time through the multi-cycle FP ALU
// Revision : 1.0 - initial release
// ============================================================================
module fpu_seq_ctrl #(
    parameter int LAT_ADD  = 7,
    parameter int LAT_MUL  = 5,
    parameter int LAT_DIV  = 6,
    parameter int LAT_SQRT = 16,
    parameter int LAT_CMB  = 1,
    parameter int LAT_CVT  = 6,
    parameter int CNT_W    = 5
) (
    input  wire logic       iclock,
    input  wire logic       ireset,
    fpu_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_lat_add  = CNT_W'(LAT_ADD);
    localparam logic [CNT_W-1:0] c_lat_mul  = CNT_W'(LAT_MUL);
    localparam logic [CNT_W-1:0] c_lat_div  = CNT_W'(LAT_DIV);
    localparam logic [CNT_W-1:0] c_lat_sqrt = CNT_W'(LAT_SQRT);
    localparam logic [CNT_W-1:0] c_lat_cmb  = CNT_W'(LAT_CMB);
    localparam logic [CNT_W-1:0] c_lat_cvt  = CNT_W'(LAT_CVT);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [3:0]       c_op_idle  = 4'hF;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_lat;
    logic               w_accept;
    logic               w_last;

    logic [3:0]         r_alu_control;
    logic [31:0]        r_alu_dataa;
    logic [31:0]        r_alu_datab;
    logic [31:0]        r_result;
    logic               r_nan;
    logic               r_zero;
    logic               r_overflow;
    logic               r_underflow;
    logic               r_comp;

    // Illegal opcodes still take one cycle so the requester always sees odone.
    always_comb begin
        w_lat = c_cnt_one;
        case (bus.iop)
            4'd0, 4'd1:                   w_lat = c_lat_add;
            4'd2:                         w_lat = c_lat_mul;
            4'd3:                         w_lat = c_lat_div;
            4'd4:                         w_lat = c_lat_sqrt;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: w_lat = c_lat_cmb;
            4'd10, 4'd11:                 w_lat = c_lat_cvt;
            default:                      w_lat = c_cnt_one;
        endcase
    end

    assign w_accept = bus.istart && (r_state != ST_EXEC);
    assign w_last   = (r_state == ST_EXEC) && (r_cnt == c_cnt_one);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC: if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclock) begin
        if (ireset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ALU inputs only change on accept, so they stay frozen for all of EXEC.
    always_ff @(posedge iclock) begin
        if (ireset) begin
            r_cnt         <= '0;
            r_alu_control <= c_op_idle;
            r_alu_dataa   <= '0;
            r_alu_datab   <= '0;
        end else if (w_accept) begin
            r_cnt         <= w_lat;
            r_alu_control <= bus.iop;
            r_alu_dataa   <= bus.idataa;
            r_alu_datab   <= bus.idatab;
        end else if (r_state == ST_EXEC) begin
            r_cnt         <= r_cnt - c_cnt_one;
        end
    end

    always_ff @(posedge iclock) begin
        if (ireset) begin
            r_result    <= '0;
            r_nan       <= 1'b0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_comp      <= 1'b0;
        end else if (w_last) begin
            r_result    <= bus.ialu_result;
            r_nan       <= bus.ialu_nan;
            r_zero      <= bus.ialu_zero;
            r_overflow  <= bus.ialu_overflow;
            r_underflow <= bus.ialu_underflow;
            r_comp      <= bus.ialu_comp;
        end
    end

    assign bus.oready       = (r_state != ST_EXEC);
    assign bus.obusy        = (r_state == ST_EXEC);
    assign bus.odone        = (r_state == ST_DONE);
    assign bus.oalu_control = r_alu_control;
    assign bus.oalu_dataa   = r_alu_dataa;
    assign bus.oalu_datab   = r_alu_datab;
    assign bus.oresult      = r_result;
    assign bus.onan         = r_nan;
    assign bus.ozero        = r_zero;
    assign bus.ooverflow    = r_overflow;
    assign bus.ounderflow   = r_underflow;
    assign bus.oCompResult  = r_comp;

endmodule
`default_nettype wire

// File: tb/tb_fpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_seq_ctrl
// Brief    : Directed bench for fpu_seq_ctrl with a latency-accurate ALU model
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_seq_ctrl;

    typedef struct {
        int unsigned cyc;
        logic [31:0] res;
        logic [4:0]  flg;   // {nan, zero, overflow, underflow, comp}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned age = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    fpu_seq_ctrl_if bus_if ();

    fpu_seq_ctrl u_dut (
        .iclock (clk),
        .ireset (rst),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edges since the ALU inputs last changed; results are garbage until the core latency elapses.
    always @(posedge clk) begin
        if (bus_if.istart && bus_if.oready && !rst) age <= 0;
        else if (age < 100) age <= age + 1;
    end

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'd0, 4'd1:                   return 7;
            4'd2:                         return 5;
            4'd3:                         return 6;
            4'd4:                         return 16;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: return 1;
            4'd10, 4'd11:                 return 6;
            default:                      return 1;
        endcase
    endfunction

    function automatic real s2r(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return 0.0;
        e = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [36:0] alu_eval(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic        cmp;
        res = 32'd0;
        cmp = 1'b0;
        case (op)
            4'd0:  res = r2s(s2r(a) + s2r(b));
            4'd1:  res = r2s(s2r(a) - s2r(b));
            4'd2:  res = r2s(s2r(a) * s2r(b));
            4'd3:  res = r2s(s2r(a) / s2r(b));
            4'd4:  res = r2s($sqrt(s2r(a)));
            4'd5:  res = {1'b0, a[30:0]};
            4'd6:  res = {~a[31], a[30:0]};
            4'd7:  cmp = (s2r(a) == s2r(b));
            4'd8:  cmp = (s2r(a) <  s2r(b));
            4'd9:  cmp = (s2r(a) <= s2r(b));
            4'd10: res = r2s(real'($signed(a)));
            4'd11: res = $rtoi(s2r(a));
            default: res = 32'd0;
        endcase
        if (op < 4'd7 || op == 4'd10)
            return {res, 1'b0, (res[30:0] == 31'd0), 3'b000};
        return {res, 4'b0000, cmp};
    endfunction

    always_comb begin
        logic [36:0] v;
        v = alu_eval(bus_if.oalu_control, bus_if.oalu_dataa, bus_if.oalu_datab);
        if (int'(age) < lat_of(bus_if.oalu_control) - 1)
            v = {32'hDEADBEEF, 5'b11111};
        bus_if.ialu_result    = v[36:5];
        bus_if.ialu_nan       = v[4];
        bus_if.ialu_zero      = v[3];
        bus_if.ialu_overflow  = v[2];
        bus_if.ialu_underflow = v[1];
        bus_if.ialu_comp      = v[0];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {bus_if.onan, bus_if.ozero, bus_if.ooverflow, bus_if.ounderflow, bus_if.oCompResult};
    endfunction

    // Scoreboard: every odone must match the oldest outstanding op in timing, result and flags.
    always @(negedge clk) begin
        if (!rst && bus_if.odone === 1'b1) begin
            chk("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("result", 64'(bus_if.oresult), 64'(e.res));
                chk("flags", 64'(flags_now()), 64'(e.flg));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [4:0] flg, input bit push);
        bus_if.istart = 1'b1;
        bus_if.iop    = op;
        bus_if.idataa = a;
        bus_if.idatab = b;
        chk("ready_at_issue", 64'(bus_if.oready), 64'd1);
        step(1);
        if (push) sb.push_back('{cyc + lat_of(op), res, flg});
        bus_if.istart = 1'b0;
        chk("alu_ctrl_latched", 64'(bus_if.oalu_control), 64'(op));
        chk("alu_a_latched", 64'(bus_if.oalu_dataa), 64'(a));
        chk("alu_b_latched", 64'(bus_if.oalu_datab), 64'(b));
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            step(1);
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.istart = 1'b0;
        bus_if.iop    = 4'd0;
        bus_if.idataa = 32'd0;
        bus_if.idatab = 32'd0;
        step(3);
        rst = 1'b0;

        // Reset state and quiet idle
        chk("rst_alu_ctrl", 64'(bus_if.oalu_control), 64'hF);
        chk("rst_alu_a", 64'(bus_if.oalu_dataa), 64'd0);
        chk("rst_flags", 64'(flags_now()), 64'd0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_ready", 64'(bus_if.oready), 64'd1);
            chk("idle_busy", 64'(bus_if.obusy), 64'd0);
            chk("idle_done", 64'(bus_if.odone), 64'd0);
            chk("idle_result", 64'(bus_if.oresult), 64'd0);
            step(1);
        end

        // ADDS 1.0 + 2.0: busy for exactly 7 cycles
        issue(4'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 5'b00000, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("add_busy", 64'(bus_if.obusy), 64'd1);
            chk("add_not_ready", 64'(bus_if.oready), 64'd0);
            step(1);
        end
        chk("add_done", 64'(bus_if.odone), 64'd1);
        chk("add_busy_low", 64'(bus_if.obusy), 64'd0);
        drain(5);
        step(3);
        chk("hold_result", 64'(bus_if.oresult), 64'h40400000);
        chk("hold_alu_ctrl", 64'(bus_if.oalu_control), 64'd0);

        // Illegal opcode: one-cycle op yielding all zeros
        issue(4'hF, 32'h12345678, 32'h9ABCDEF0, 32'd0, 5'b00000, 1'b1);
        drain(5);

        // SQRT 16.0 with a stray MULS request while in flight
        issue(4'd4, 32'h41800000, 32'h00000000, 32'h40800000, 5'b00000, 1'b1);
        step(4);
        bus_if.istart = 1'b1;
        bus_if.iop    = 4'd2;
        bus_if.idataa = 32'h40000000;
        bus_if.idatab = 32'h40000000;
        chk("sqrt_ignore_ready", 64'(bus_if.oready), 64'd0);
        step(1);
        bus_if.istart = 1'b0;
        chk("sqrt_ignore_ctrl", 64'(bus_if.oalu_control), 64'd4);
        chk("sqrt_ignore_a", 64'(bus_if.oalu_dataa), 64'h41800000);
        drain(30);
        step(5);

        // Back-to-back: CLT then DIVS accepted in the DONE cycle
        issue(4'd8, 32'hBF800000, 32'h3F800000, 32'd0, 5'b00001, 1'b1);
        step(1);
        chk("b2b_done_cycle", 64'(bus_if.odone), 64'd1);
        issue(4'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b1);
        chk("b2b_busy", 64'(bus_if.obusy), 64'd1);
        drain(20);
        step(2);
        chk("hold_div_result", 64'(bus_if.oresult), 64'h40400000);

        // MULS aborted by reset three cycles after accept
        issue(4'd2, 32'h40000000, 32'h40400000, 32'd0, 5'b00000, 1'b0);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("abort_ready", 64'(bus_if.oready), 64'd1);
        chk("abort_busy", 64'(bus_if.obusy), 64'd0);
        chk("abort_result", 64'(bus_if.oresult), 64'd0);
        chk("abort_flags", 64'(flags_now()), 64'd0);
        chk("abort_alu_ctrl", 64'(bus_if.oalu_control), 64'hF);
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_done", 64'(bus_if.odone), 64'd0);
            step(1);
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
